bus_rr_router: RTL and testbench
================================

// Module: bus_rr_router
// PURPOSE
// Parametrised successor of the single-bus generator/arbiter. Connects DRVRS source FIFOs (show-ahead, pndng/pop/D_pop)
// to DRVRS destination FIFOs (push/D_push) over one shared bus. Adds round-robin fairness, destination backpressure
// (full), a configurable ID field, optional self-broadcast, a stall timeout with drop, and error/packet counters.
// Sits between the driver FIFOs and the bus interface; the environment's drivers and monitors attach per port.
// PARAMETERS
// DRVRS       4          number of source/destination ports (2..16)
// PCKG_SZ     32         packet width in bits; destination ID is the top ID_W bits
// ID_W        8          destination ID field width (ID_W < PCKG_SZ)
// BROADCAST   {ID_W{1}}  ID value that selects every destination
// SELF_BCAST  0          1: a broadcast also pushes to its own source port
// TIMEOUT     64         maximum cycles stalled in ROUTE before the packet is dropped (>=1)
// PORTS
// clk             in   1              clock, rising edge
// reset           in   1              asynchronous, active-low reset
// pndng           in   DRVRS          source i FIFO non-empty
// D_pop           in   DRVRS*PCKG_SZ  head packet of source i (slice i), valid while pndng[i]
// pop             out  DRVRS          one-cycle pop strobe to source i
// full            in   DRVRS          destination i cannot accept a push
// push            out  DRVRS          one-cycle push strobe to destination i
// D_push          out  PCKG_SZ        packet on the bus, common to all destinations
// err_bad_id      out  1              one-cycle pulse: invalid destination, packet dropped
// err_timeout     out  1              one-cycle pulse: stall timeout, packet dropped
// pkt_count       out  16             delivered packets, wraps at 2^16
// BEHAVIOUR
// - Reset (reset==0, async): state=IDLE, pop=0, push=0, D_push=0, errors=0, pkt_count=0, last_grant=DRVRS-1,
//   stall counter=0. A packet already popped when reset asserts is lost; this is intended.
// - FSM IDLE -> POP -> ROUTE -> IDLE. pop/push/err outputs decode from registered state/regs only (no input paths).
// - IDLE: if |pndng, winner = first set bit scanning last_grant+1, +2, ... mod DRVRS; register src=winner; go POP.
//   If no pndng, stay IDLE.
// - POP: pop[src]=1 for exactly this cycle; pkt_reg<=D_pop[src]; last_grant<=src; go ROUTE.
// - ROUTE: dest=pkt_reg[PCKG_SZ-1 -: ID_W].
//   - dest==BROADCAST: targets=all ports, minus src when SELF_BCAST=0.
//   - dest<DRVRS and dest!=src: targets=onehot(dest).
//   - Otherwise (out of range, or dest==src): err_bad_id=1 next cycle; drop; go IDLE.
//   - If any target has full=1: stay in ROUTE and increment the stall counter. When the counter reaches TIMEOUT:
//     err_timeout=1 next cycle; drop; go IDLE.
//   - Else push[targets]=1 for one cycle with D_push=pkt_reg; pkt_count+=1; go IDLE.
//   - Broadcast is all-or-nothing; never a partial push.
// - Throughput: 3 cycles per packet minimum (IDLE, POP, ROUTE). Latency from pndng to push is 3 edges with no stall.
// - D_push holds pkt_reg at all times. Destinations sample it only when push is high.
// - Simultaneous pndng: only the round-robin winner is popped. A port that won is lowest priority next round.
// - pndng dropping between IDLE and POP is a source protocol violation; no recovery is defined.
// - Stall counter clears on entry to ROUTE.
// STRUCTURE
// - Package bus_rr_pkg: state_t enum {IDLE,POP,ROUTE}, function dest_of(pkt), localparam CNT_W=16.
// - Sub-module bus_rr_pick #(DRVRS): combinational rotate-priority pick(req, last) -> grant idx + valid.
// - Top: FSM, pkt_reg, stall counter, target decode, counters.
// TESTING (DRVRS=4, PCKG_SZ=32, ID_W=8, TIMEOUT=8)
// - Reset mid-ROUTE: reset low for 1 cycle -> all outputs 0, pkt_count=0, next grant goes to port 0.
// - Port 1 head 0x02_00ABCD, others idle -> pop[1] at edge 2, push=4'b0100, D_push=0x0200ABCD at edge 3,
//   pkt_count=1.
// - pndng=4'b1111 held, every dest free -> pop order 0,1,2,3,0 and each grant exactly 3 cycles apart.
// - Port 0 broadcast 0xFF_000001, SELF_BCAST=0 -> push=4'b1110 in a single cycle.
//   With full[2]=1 for 5 cycles, push=4'b1110 occurs after the release and never partial.
// - Port 3 packet 0x03_..., then 0x09_... -> err_bad_id pulses once for each; push stays 0; pkt_count unchanged.
// - Port 2 to dest 1 with full[1] stuck high -> err_timeout after 8 stall cycles; FSM returns to IDLE;
//   the next pndng is served.

Source files
------------

// File: rtl/bus_rr_pkg.sv
// Shared types and helpers for the round-robin single-bus router.
package bus_rr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POP   = 2'd1,
        ROUTE = 2'd2
    } state_t;

    localparam int CNT_W       = 16;
    localparam int MAX_PCKG_SZ = 256;
    localparam int MAX_ID_W    = 32;

    // Destination ID is the top id_w bits of a pckg_sz-bit packet.
    function automatic logic [MAX_ID_W-1:0] dest_of(input logic [MAX_PCKG_SZ-1:0] pkt,
                                                    input int pckg_sz,
                                                    input int id_w);
        logic [MAX_ID_W-1:0] mask;
        mask = (id_w >= MAX_ID_W) ? '1 : ((MAX_ID_W'(1) << id_w) - MAX_ID_W'(1));
        return MAX_ID_W'(pkt >> (pckg_sz - id_w)) & mask;
    endfunction

endpackage

// File: rtl/bus_rr_router_if.sv
// Source/destination FIFO handshake bundle shared by the router and its environment.
interface bus_rr_router_if #(
    parameter int DRVRS   = 4,
    parameter int PCKG_SZ = 32
) ();
    logic [DRVRS-1:0]         pndng;
    logic [DRVRS*PCKG_SZ-1:0] D_pop;
    logic [DRVRS-1:0]         pop;
    logic [DRVRS-1:0]         full;
    logic [DRVRS-1:0]         push;
    logic [PCKG_SZ-1:0]       D_push;

    modport master (
        input  pndng, D_pop, full,
        output pop, push, D_push
    );

    modport slave (
        output pndng, D_pop, full,
        input  pop, push, D_push
    );
endinterface

// File: rtl/bus_rr_pick.sv
// Rotating-priority picker: first requester after last_i, wrapping modulo DRVRS.
module bus_rr_pick #(
    parameter int DRVRS = 4,
    parameter int IDX_W = (DRVRS > 1) ? $clog2(DRVRS) : 1
) (
    input  logic [DRVRS-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [IDX_W-1:0] grant_o,
    output logic             valid_o
);
    logic [IDX_W-1:0] idx;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        grant_o = '0;
        idx     = '0;
        valid_o = |req_i;
        // Scan farthest-first so the port right after last_i overwrites everyone else.
        for (int off = DRVRS; off >= 1; off--) begin
            idx = IDX_W'((int'(last_i) + off) % DRVRS);
            if (req_i[idx]) begin
                grant_o = idx;
            end
        end
    end
endmodule

// File: rtl/bus_rr_router.sv
// Round-robin router: pops one source FIFO at a time and pushes it to one or all destinations.
module bus_rr_router
    import bus_rr_pkg::*;
#(
    parameter int              DRVRS      = 4,
    parameter int              PCKG_SZ    = 32,
    parameter int              ID_W       = 8,
    parameter logic [ID_W-1:0] BROADCAST  = '1,
    parameter bit              SELF_BCAST = 1'b0,
    parameter int              TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             reset,
    bus_rr_router_if.master  bus,
    output logic             err_bad_id,
    output logic             err_timeout,
    output logic [CNT_W-1:0] pkt_count
);
    localparam int IDX_W   = (DRVRS > 1) ? $clog2(DRVRS) : 1;
    localparam int STALL_W = $clog2(TIMEOUT + 1);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     src_q, src_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [PCKG_SZ-1:0]   pkt_q, pkt_d;
    logic [STALL_W-1:0]   stall_q, stall_d;
    logic [DRVRS-1:0]     pop_q, pop_d;
    logic [DRVRS-1:0]     push_q, push_d;
    logic                 bad_q, bad_d;
    logic                 to_q, to_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [IDX_W-1:0]     grant;
    logic                 grant_vld;
    logic [ID_W-1:0]      dest;
    logic [DRVRS-1:0]     src_mask;
    logic [DRVRS-1:0]     targets;
    logic                 id_ok;
    logic                 blocked;
    logic [PCKG_SZ-1:0]   d_pop_arr [DRVRS];

    for (genvar g = 0; g < DRVRS; g++) begin : g_slice
        assign d_pop_arr[g] = bus.D_pop[g*PCKG_SZ +: PCKG_SZ];
    end

    bus_rr_pick #(
        .DRVRS (DRVRS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (bus.pndng),
        .last_i  (last_q),
        .grant_o (grant),
        .valid_o (grant_vld)
    );

    // Target decode from the held packet; broadcast is all-or-nothing via the single blocked flag.
    always_comb begin
        dest     = ID_W'(dest_of(MAX_PCKG_SZ'(pkt_q), PCKG_SZ, ID_W));
        src_mask = DRVRS'(1) << src_q;
        targets  = '0;
        id_ok    = 1'b0;
        if (dest == BROADCAST) begin
            targets = SELF_BCAST ? '1 : ~src_mask;
            id_ok   = 1'b1;
        end else if ((32'(dest) < 32'(DRVRS)) && (32'(dest) != 32'(src_q))) begin
            targets = DRVRS'(1) << dest;
            id_ok   = 1'b1;
        end
        blocked = |(targets & bus.full);
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        last_d  = last_q;
        pkt_d   = pkt_q;
        stall_d = stall_q;
        pop_d   = '0;
        push_d  = '0;
        bad_d   = 1'b0;
        to_d    = 1'b0;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    src_d   = grant;
                    pop_d   = DRVRS'(1) << grant;
                    state_d = POP;
                end
            end
            POP: begin
                pkt_d   = d_pop_arr[src_q];
                last_d  = src_q;
                stall_d = '0;
                state_d = ROUTE;
            end
            ROUTE: begin
                if (!id_ok) begin
                    bad_d   = 1'b1;
                    state_d = IDLE;
                end else if (blocked) begin
                    if (stall_q == STALL_W'(TIMEOUT - 1)) begin
                        to_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        stall_d = stall_q + STALL_W'(1);
                    end
                end else begin
                    push_d  = targets;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            last_q  <= IDX_W'(DRVRS - 1);
            // NOTE: the packet register is reset too, because D_push is visible on the bus at all times.
            pkt_q   <= '0;
            stall_q <= '0;
            pop_q   <= '0;
            push_q  <= '0;
            bad_q   <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking updates so every register sees the pre-edge value of every other.
            state_q <= state_d;
            src_q   <= src_d;
            last_q  <= last_d;
            pkt_q   <= pkt_d;
            stall_q <= stall_d;
            pop_q   <= pop_d;
            push_q  <= push_d;
            bad_q   <= bad_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.pop     = pop_q;
    assign bus.push    = push_q;
    assign bus.D_push  = pkt_q;
    assign err_bad_id  = bad_q;
    assign err_timeout = to_q;
    assign pkt_count   = cnt_q;
endmodule

// File: tb/tb_bus_rr_router.sv
// Directed bench for bus_rr_router with DRVRS=4, PCKG_SZ=32, ID_W=8, TIMEOUT=8.
module tb_bus_rr_router;
    import bus_rr_pkg::*;

    logic             clk   = 1'b0;
    logic             reset = 1'b1;
    logic             err_bad_id;
    logic             err_timeout;
    logic [CNT_W-1:0] pkt_count;
    logic [31:0]      d_pop [4];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  port;
        logic [31:0] pkt;
        logic [3:0]  exp_push;
        logic        exp_bad;
        int          exp_cnt;
    } vec_t;

    vec_t vecs [8];

    bus_rr_router_if #(.DRVRS(4), .PCKG_SZ(32)) bus ();

    assign bus.D_pop = {d_pop[3], d_pop[2], d_pop[1], d_pop[0]};

    bus_rr_router #(
        .DRVRS      (4),
        .PCKG_SZ    (32),
        .ID_W       (8),
        .BROADCAST  (8'hFF),
        .SELF_BCAST (1'b0),
        .TIMEOUT    (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .err_bad_id  (err_bad_id),
        .err_timeout (err_timeout),
        .pkt_count   (pkt_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Offer one packet on a port, release it after the pop edge, then wait for push or an error pulse.
    task automatic run_pkt(input logic [1:0] port, input logic [31:0] pkt,
                           output logic [3:0] pop_s, output logic [3:0] push_s,
                           output logic [31:0] data_s, output logic bad_s, output logic to_s,
                           output int lat, output logic pulse_ok);
        pop_s    = '0;
        push_s   = '0;
        data_s   = '0;
        bad_s    = 1'b0;
        to_s     = 1'b0;
        lat      = -1;
        pulse_ok = 1'b0;
        d_pop[port]     = pkt;
        bus.pndng[port] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pop_s = bus.pop;
            if (pop_s != 4'b0000) break;
        end
        @(posedge clk);
        #1;
        bus.pndng[port] = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.push != 4'b0000 || err_bad_id || err_timeout) begin
                push_s = bus.push;
                data_s = bus.D_push;
                bad_s  = err_bad_id;
                to_s   = err_timeout;
                lat    = i;
                break;
            end
        end
        if (lat > 0) begin
            @(negedge clk);
            pulse_ok = (bus.push == 4'b0000) && !err_bad_id && !err_timeout;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  pop_s, push_s;
        logic [31:0] data_s;
        logic        bad_s, to_s, pulse_s, seen_push;
        int          lat, npop;
        logic [3:0]  pops [5];
        int          tpop [5];

        bus.pndng = '0;
        bus.full  = '0;
        for (int i = 0; i < 4; i++) d_pop[i] = '0;

        vecs[0] = '{port: 2'd1, pkt: 32'h0200ABCD, exp_push: 4'b0100, exp_bad: 1'b0, exp_cnt: 1};
        vecs[1] = '{port: 2'd0, pkt: 32'hFF000001, exp_push: 4'b1110, exp_bad: 1'b0, exp_cnt: 2};
        vecs[2] = '{port: 2'd3, pkt: 32'h03000000, exp_push: 4'b0000, exp_bad: 1'b1, exp_cnt: 2};
        vecs[3] = '{port: 2'd3, pkt: 32'h09000000, exp_push: 4'b0000, exp_bad: 1'b1, exp_cnt: 2};
        vecs[4] = '{port: 2'd2, pkt: 32'h00001234, exp_push: 4'b0001, exp_bad: 1'b0, exp_cnt: 3};
        vecs[5] = '{port: 2'd3, pkt: 32'hFF00BEEF, exp_push: 4'b0111, exp_bad: 1'b0, exp_cnt: 4};
        vecs[6] = '{port: 2'd1, pkt: 32'h01000055, exp_push: 4'b0000, exp_bad: 1'b1, exp_cnt: 4};
        vecs[7] = '{port: 2'd2, pkt: 32'h0F000000, exp_push: 4'b0000, exp_bad: 1'b1, exp_cnt: 4};

        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst pop", bus.pop, 4'b0000);
        check("rst push", bus.push, 4'b0000);
        check("rst D_push", bus.D_push, 32'h0);
        check("rst err_bad_id", err_bad_id, 1'b0);
        check("rst err_timeout", err_timeout, 1'b0);
        check("rst pkt_count", pkt_count, 16'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_pkt(vecs[i].port, vecs[i].pkt, pop_s, push_s, data_s, bad_s, to_s, lat, pulse_s);
            check($sformatf("v%0d pop", i), pop_s, 4'b0001 << vecs[i].port);
            check($sformatf("v%0d push", i), push_s, vecs[i].exp_push);
            check($sformatf("v%0d D_push", i), data_s, vecs[i].pkt);
            check($sformatf("v%0d err_bad_id", i), bad_s, vecs[i].exp_bad);
            check($sformatf("v%0d err_timeout", i), to_s, 1'b0);
            check($sformatf("v%0d latency", i), lat, 2);
            check($sformatf("v%0d one-cycle", i), pulse_s, 1'b1);
            check($sformatf("v%0d pkt_count", i), pkt_count, vecs[i].exp_cnt);
        end

        // Reset while a packet from port 2 sits in ROUTE; it is lost and last_grant returns to 3.
        d_pop[2]     = 32'h03000077;
        bus.pndng[2] = 1'b1;
        pop_s        = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pop_s = bus.pop;
            if (pop_s != 4'b0000) break;
        end
        check("midrst pop", pop_s, 4'b0100);
        @(posedge clk);
        #1 bus.pndng[2] = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("midrst pop out", bus.pop, 4'b0000);
        check("midrst push", bus.push, 4'b0000);
        check("midrst D_push", bus.D_push, 32'h0);
        check("midrst errors", {err_bad_id, err_timeout}, 2'b00);
        check("midrst pkt_count", pkt_count, 16'd0);
        @(negedge clk);
        reset = 1'b1;

        // All four ports pending: grants rotate 0,1,2,3,0 three cycles apart.
        for (int i = 0; i < 4; i++) d_pop[i] = {8'((i + 1) % 4), 24'(i)};
        for (int k = 0; k < 5; k++) begin
            pops[k] = '0;
            tpop[k] = 0;
        end
        bus.pndng = 4'b1111;
        npop      = 0;
        for (int c = 0; c < 40 && npop < 5; c++) begin
            @(negedge clk);
            if (bus.pop != 4'b0000) begin
                pops[npop] = bus.pop;
                tpop[npop] = c;
                npop++;
            end
        end
        @(posedge clk);
        #1 bus.pndng = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rr pop %0d", k), pops[k], 4'b0001 << (k % 4));
            if (k > 0) check($sformatf("rr gap %0d", k), tpop[k] - tpop[k-1], 3);
        end
        repeat (6) @(negedge clk);
        check("rr pkt_count", pkt_count, 16'd5);

        // Broadcast from port 0 with destination 2 full for five cycles: no partial push.
        bus.full     = 4'b0100;
        d_pop[0]     = 32'hFF000001;
        bus.pndng[0] = 1'b1;
        pop_s        = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pop_s = bus.pop;
            if (pop_s != 4'b0000) break;
        end
        check("bstall pop", pop_s, 4'b0001);
        @(posedge clk);
        #1 bus.pndng[0] = 1'b0;
        seen_push = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.push != 4'b0000) seen_push = 1'b1;
        end
        check("bstall no push while full", seen_push, 1'b0);
        bus.full = 4'b0000;
        push_s   = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            push_s = bus.push;
            if (push_s != 4'b0000) break;
        end
        check("bstall push", push_s, 4'b1110);
        check("bstall D_push", bus.D_push, 32'hFF000001);
        @(negedge clk);
        check("bstall one-cycle", bus.push, 4'b0000);
        check("bstall pkt_count", pkt_count, 16'd6);

        // Destination 1 stuck full: eight blocked ROUTE cycles, then timeout and drop.
        bus.full = 4'b0010;
        run_pkt(2'd2, 32'h010000AA, pop_s, push_s, data_s, bad_s, to_s, lat, pulse_s);
        check("to pop", pop_s, 4'b0100);
        check("to push", push_s, 4'b0000);
        check("to err_timeout", to_s, 1'b1);
        check("to err_bad_id", bad_s, 1'b0);
        check("to latency", lat, 9);
        check("to one-cycle", pulse_s, 1'b1);
        check("to pkt_count", pkt_count, 16'd6);
        bus.full = 4'b0000;

        run_pkt(2'd1, 32'h00000042, pop_s, push_s, data_s, bad_s, to_s, lat, pulse_s);
        check("after-to pop", pop_s, 4'b0010);
        check("after-to push", push_s, 4'b0001);
        check("after-to D_push", data_s, 32'h00000042);
        check("after-to latency", lat, 2);
        check("after-to pkt_count", pkt_count, 16'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
